// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RISC-V core.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched entries; head is presented from storage and zeroed when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    fetch_entry_t r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && (!o_full || w_pop) && !i_flush;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per cycle into a FIFO, handles redirects.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_misaligned
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;

    logic         w_push;
    logic         w_pop;
    logic         w_fetch;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    assign imem_addr = r_pc;
    assign w_pop     = id_valid && id_ready;
    // A pop this cycle frees the slot the new fetch lands in.
    assign w_fetch   = (r_state == RUN) && !redirect_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_entry      = '0;
        if (redirect_valid) begin
            w_pc_next    = redirect_pc;
            w_state_next = RUN;
        end else if (w_fetch) begin
            w_push = 1'b1;
            if (r_pc[1:0] == 2'b00) begin
                w_entry   = '{pc: r_pc, instr: imem_rdata, misaligned: 1'b0};
                w_pc_next = pc_plus4(r_pc);
            end else begin
                // Misaligned target: hand decode a NOP marker and stop until redirected.
                w_entry      = '{pc: r_pc, instr: NOP_INSTR, misaligned: 1'b1};
                w_state_next = HALT;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign id_valid      = !w_empty;
    assign id_instr      = w_head.instr;
    assign id_pc         = w_head.pc;
    assign id_misaligned = w_head.misaligned;
    assign id_pc_plus4   = w_empty ? 32'h0 : pc_plus4(w_head.pc);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a queue-based fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_misaligned;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_misaligned  (id_misaligned)
    );

    logic [31:0] init_words [4] = '{32'h0031_02b3, 32'h4082_8233, 32'h0062_a023, 32'h00c0_00ef};

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2];
        if (idx < 30'd4) return init_words[idx[1:0]];
        return ({2'b00, idx} * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } m_entry_t;

    m_entry_t    m_q[$];
    logic [31:0] m_pc     = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_known  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        check("id_valid", {31'h0, id_valid}, {31'h0, m_q.size() != 0});
        check("imem_addr", imem_addr, m_pc);
        if (m_q.size() != 0) begin
            check("id_pc", id_pc, m_q[0].pc);
            check("id_instr", id_instr, m_q[0].instr);
            check("id_pc_plus4", id_pc_plus4, m_q[0].pc + 32'd4);
            check("id_misaligned", {31'h0, id_misaligned}, {31'h0, m_q[0].mis});
        end else begin
            check("id_zero", {id_pc ^ id_instr ^ id_pc_plus4} | {31'h0, id_misaligned}
                  | id_pc | id_instr | id_pc_plus4, 32'h0);
        end
    endtask

    task automatic model_edge(input logic rn, input logic rv, input logic [31:0] rp,
                              input logic rdy);
        if (!rn) begin
            m_q.delete();
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_known  = 1'b1;
        end else if (rv) begin
            m_q.delete();
            m_pc     = rp;
            m_halted = 1'b0;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (!m_halted && m_q.size() < DEPTH) begin
                if (m_pc[1:0] == 2'b00) begin
                    m_q.push_back('{pc: m_pc, instr: mem_word(m_pc), mis: 1'b0});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_q.push_back('{pc: m_pc, instr: NOP, mis: 1'b1});
                    m_halted = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then advance the model across the edge.
    task automatic step(input logic rn, input logic rv, input logic [31:0] rp, input logic rdy);
        rstn           = rn;
        redirect_valid = rv;
        redirect_pc    = rp;
        id_ready       = rdy;
        @(negedge clk);
        if (m_known) compare_all();
        model_edge(rn, rv, rp, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;

        do_reset();
        check("pin_reset_valid", {31'h0, id_valid}, 32'h0);
        check("pin_reset_addr", imem_addr, RESET_PC);

        run(1, 1'b1);
        check("pin_first_pc", id_pc, 32'h0);
        check("pin_first_instr", id_instr, 32'h0031_02b3);
        run(1, 1'b1);
        check("pin_second_instr", id_instr, 32'h4082_8233);
        check("pin_second_plus4", id_pc_plus4, 32'h8);
        run(3, 1'b1);

        do_reset();
        run(6, 1'b0);
        check("pin_full_addr", imem_addr, 32'h8);
        check("pin_full_head", id_pc, 32'h0);
        run(6, 1'b1);

        run(3, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
        check("pin_flush_empty", {31'h0, id_valid}, 32'h0);
        check("pin_flush_addr", imem_addr, 32'h40);
        run(1, 1'b1);
        check("pin_redirect_pc", id_pc, 32'h40);
        run(3, 1'b1);

        step(1'b1, 1'b1, 32'h0000_0042, 1'b0);
        run(1, 1'b0);
        check("pin_mis_flag", {31'h0, id_misaligned}, 32'h1);
        check("pin_mis_instr", id_instr, 32'h0000_0013);
        check("pin_mis_pc", id_pc, 32'h42);
        run(1, 1'b1);
        run(4, 1'b1);
        check("pin_halt_idle", {31'h0, id_valid}, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0010, 1'b1);
        run(3, 1'b1);

        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(2, 1'b1);
        check("pin_wrap_addr", imem_addr, 32'h0);
        check("pin_wrap_plus4", id_pc_plus4, 32'h0);
        check("pin_wrap_pc", id_pc, 32'hFFFF_FFFC);
        run(3, 1'b1);

        run(3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("pin_midreset_valid", {31'h0, id_valid}, 32'h0);
        check("pin_midreset_addr", imem_addr, RESET_PC);
        run(4, 1'b1);

        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            tgt = $urandom;
            if (r[2:0] != 3'b000) tgt[1:0] = 2'b00;
            if (r[15:8] < 8'd3) step(1'b0, r[16], tgt, r[17]);
            else if (r[15:8] < 8'd16) step(1'b1, 1'b1, tgt, r[17]);
            else step(1'b1, 1'b0, 32'h0, r[23:20] < 4'd11);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core. Owns the program counter and drives the byte address into the instruction memory, which returns data combinationally in the same cycle. Each fetched word is captured with its PC into a small FIFO and handed to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the FIFO and restart fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- DEPTH, 2: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  Core clock; all state updates on the rising edge.
- rstn  in  1  Reset, synchronous, active-low.
- imem_addr  out  32  Byte address to instruction memory; memory indexes word addr>>2.
- imem_rdata  in  32  Instruction word, valid combinationally in the same cycle.
- redirect_valid  in  1  Redirect request this cycle.
- redirect_pc  in  32  Redirect target byte address.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  Decode accepts the head this cycle.
- id_instr  out  32  Head instruction.
- id_pc  out  32  Head PC.
- id_pc_plus4  out  32  Head PC + 4, modulo 2^32.
- id_misaligned  out  1  Head is a misaligned-fetch marker.

## Operation
- State machine with two states:
  - RUN: normal fetch.
  - HALT: fetch stopped after a misaligned target.
- imem_addr = pc at all times, including HALT.
- Fetch condition: state==RUN, no redirect this cycle, and the FIFO is either not full or is popped this cycle.
- On fetch:
  - pc[1:0]==0: push {pc, imem_rdata, 0}; pc <= pc+4 (wraps at 2^32).
  - pc[1:0]!=0: push {pc, NOP 32'h0000_0013, 1}; state <= HALT; pc holds.
- Pop when id_valid && id_ready.
- Redirect (redirect_valid=1) has priority over everything:
  - FIFO flushed (count <= 0); any pop that cycle is discarded.
  - No push that cycle.
  - pc <= redirect_pc; state <= RUN.
- HALT exits only via redirect or reset.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are decided from the MSB difference; pointers wrap naturally.
- Simultaneous push and pop on a full FIFO: both occur and count is unchanged.
- Simultaneous push and pop on an empty FIFO: nothing is popped because id_valid=0; the entry is pushed.
- Reset (rstn=0 at an edge), including mid-operation: pc <= RESET_PC, state <= RUN, FIFO empty. Redirect is ignored while reset is asserted.

## Timing
- Reset values: imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, id_misaligned=0.
- id_* outputs are zero whenever id_valid=0.
- First edge with rstn=1 pushes the RESET_PC word, so id_valid=1 in the following cycle.
- Redirect asserted in cycle N:
  - imem_addr=redirect_pc in N+1.
  - Target word pushed at the end of N+1.
  - id_valid=1 with id_pc=redirect_pc in N+2.
- Steady state with id_ready=1: one instruction per cycle, no bubbles.
- id_ready=0: FIFO fills to DEPTH. pc stops at the address of the next unfetched word; imem_addr holds it.
- id_valid does not depend combinationally on id_ready or redirect_valid. All id_* outputs come directly from FIFO storage.

## Structure
- Shared package riscv_pkg holds:
  - constant NOP_INSTR = 32'h0000_0013.
  - default RESET_PC.
  - fetch_entry_t struct {pc[31:0], instr[31:0], misaligned}.
  - fetch_state_t enum {RUN, HALT}.
- Sub-module fetch_fifo: parameterized FIFO of fetch_entry_t with push, pop, flush, full, empty. It has the same synchronous active-low rstn.
- instr_fetch_unit holds the PC, the state machine and the fetch/redirect control.

## Test plan
- Reset, then 5 cycles with id_ready=1 against memory preloaded with 0x003102b3, 0x40828233, ... → id_valid from cycle 2; id_pc 0, 4, 8, 12 and id_instr matching memory each cycle; id_pc_plus4 = id_pc+4.
- Hold id_ready=0 for 6 cycles after reset → exactly DEPTH entries buffered and imem_addr holds 8. Then release id_ready → PCs 0, 4, 8, 12 delivered in order with no loss or duplication.
- Redirect to 0x40 while the FIFO is full and id_ready=1 → the head is not counted as consumed, the FIFO is empty the next cycle, and id_pc=0x40 two cycles after the redirect.
- Redirect to 0x42 → one entry with id_misaligned=1, id_instr=0x00000013, id_pc=0x42. id_valid stays 0 afterwards until a redirect to 0x10, which resumes at 0x10.
- Set pc near 0xFFFF_FFFC via redirect → the following fetch address is 0x0, and id_pc_plus4=0x0 for the 0xFFFF_FFFC entry.
- Assert rstn=0 for one edge mid-stream with the FIFO holding 2 entries → next cycle id_valid=0, imem_addr=RESET_PC, and fetch restarts from RESET_PC.
